row_feeder: RTL

Producer that drives the row_buffer chain input side: datain/datain_valid stream, delay, initialize.
- Pulls raw pixels from an upstream ready/valid source in raster order.
- Surrounds the frame with cfg_pad zero pixels on all four borders, so convolution windows are correctly padded.
- Drives delay with the padded row width and pulses initialize once per frame.
- Sits between the frame fetch FIFO and the first row_buffer of the window generator.

---
 rtl/row_feeder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/row_feeder.sv
// row_feeder: pulls raster-order pixels from an upstream ready/valid source and
// wraps the frame in cfg_pad zero pixels on every border before handing the
// padded stream to the first row_buffer. Also drives the row_buffer delay
// (padded row width) and a one-cycle initialize pulse per frame.
module row_feeder #(
  parameter int C_DATAIN_WIDTH  = 32,
  parameter int C_MAX_DELAY     = 1024,
  parameter int C_PTR_WIDTH     = $clog2(C_MAX_DELAY),
  parameter int C_ROW_CNT_WIDTH = 12,
  parameter int C_MAX_PAD       = 3,
  parameter int C_PAD_WIDTH     = $clog2(C_MAX_PAD + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [C_PTR_WIDTH-1:0]     cfg_num_cols,
  input  logic [C_ROW_CNT_WIDTH-1:0] cfg_num_rows,
  input  logic [C_PAD_WIDTH-1:0]     cfg_pad,
  input  logic [C_DATAIN_WIDTH-1:0]  src_data,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic                       stall,
  output logic                       initialize,
  output logic [C_PTR_WIDTH-1:0]     delay,
  output logic [C_DATAIN_WIDTH-1:0]  dataout,
  output logic                       dataout_valid,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_PAD_ROW, S_PAD_L, S_DATA, S_PAD_R, S_DONE
  } state_t;

  localparam logic [C_PAD_WIDTH-1:0] MAX_PAD = C_PAD_WIDTH'(C_MAX_PAD);

  state_t                      state_q, state_d;
  logic [C_PTR_WIDTH-1:0]      cols_q, delay_q;
  logic [C_ROW_CNT_WIDTH-1:0]  rows_q;
  logic [C_PAD_WIDTH-1:0]      pad_q;
  logic [C_PTR_WIDTH-1:0]      col_q, col_d;
  logic [C_ROW_CNT_WIDTH-1:0]  row_q, row_d;
  logic [C_PAD_WIDTH-1:0]      prow_q, prow_d;
  logic                        bot_q, bot_d;      // 1 once the top pad rows are done
  logic [C_DATAIN_WIDTH-1:0]   dout_q, pix;
  logic                        dvld_q, emit;
  logic                        done_q;

  // Configuration capture helpers
  logic [C_PAD_WIDTH-1:0]      pad_clamp;
  logic [C_PTR_WIDTH-1:0]      pad_cfg_w, delay_d;
  logic                        start_ok;
  assign pad_clamp = (cfg_pad > MAX_PAD) ? MAX_PAD : cfg_pad;
  assign pad_cfg_w = C_PTR_WIDTH'(pad_clamp);
  assign delay_d   = cfg_num_cols + (pad_cfg_w << 1);
  // done_q is still high the cycle after DONE, so a start then is ignored too
  assign start_ok  = start && (state_q == S_IDLE) && !done_q &&
                     (cfg_num_cols != '0) && (cfg_num_rows != '0);

  // End-of-row decision shared by DATA (P=0) and PAD_R
  logic                        has_pad, row_last;
  logic [C_PTR_WIDTH-1:0]      pad_w;
  state_t                      eor_state;
  logic [C_ROW_CNT_WIDTH-1:0]  eor_row;
  assign has_pad   = (pad_q != '0);
  assign pad_w     = C_PTR_WIDTH'(pad_q);
  assign row_last  = (row_q == rows_q - 1'b1);
  assign eor_state = row_last ? (has_pad ? S_PAD_ROW : S_DONE)
                              : (has_pad ? S_PAD_L   : S_DATA);
  assign eor_row   = row_last ? '0 : row_q + 1'b1;

  // Next-state, counter and emit logic
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    prow_d  = prow_q;
    bot_d   = bot_q;
    emit    = 1'b0;
    pix     = '0;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_INIT;
      S_INIT: begin
        col_d   = '0;
        row_d   = '0;
        prow_d  = '0;
        bot_d   = 1'b0;
        state_d = has_pad ? S_PAD_ROW : S_DATA;
      end
      S_PAD_ROW: if (!stall) begin
        emit = 1'b1;
        if (col_q == delay_q - 1'b1) begin
          col_d = '0;
          if (prow_q == pad_q - 1'b1) begin
            prow_d = '0;
            if (bot_q) state_d = S_DONE;
            else begin
              bot_d   = 1'b1;
              state_d = S_PAD_L;
            end
          end else begin
            prow_d = prow_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_PAD_L: if (!stall) begin
        emit = 1'b1;
        if (col_q == pad_w - 1'b1) begin
          col_d   = '0;
          state_d = S_DATA;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DATA: if (src_valid && !stall) begin
        emit = 1'b1;
        pix  = src_data;
        if (col_q == cols_q - 1'b1) begin
          col_d = '0;
          if (has_pad) state_d = S_PAD_R;
          else begin
            state_d = eor_state;
            row_d   = eor_row;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_PAD_R: if (!stall) begin
        emit = 1'b1;
        if (col_q == pad_w - 1'b1) begin
          col_d   = '0;
          state_d = eor_state;
          row_d   = eor_row;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and frame configuration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      prow_q  <= '0;
      bot_q   <= 1'b0;
      cols_q  <= '0;
      rows_q  <= '0;
      pad_q   <= '0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      prow_q  <= prow_d;
      bot_q   <= bot_d;
      if (start_ok) begin
        cols_q  <= cfg_num_cols;
        rows_q  <= cfg_num_rows;
        pad_q   <= pad_clamp;
        delay_q <= delay_d;
      end
    end
  end

  // Registered pixel output; data holds when nothing is emitted. done is
  // delayed one cycle so it follows the last pixel leaving this register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      dvld_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dvld_q <= emit;
      if (emit) dout_q <= pix;
      done_q <= (state_q == S_DONE);
    end
  end

  assign src_ready     = (state_q == S_DATA) && !stall;
  assign initialize    = (state_q == S_INIT);
  assign busy          = (state_q != S_IDLE) || done_q;
  assign done          = done_q;
  assign delay         = delay_q;
  assign dataout       = dout_q;
  assign dataout_valid = dvld_q;

endmodule
